// File: rtl/cpu_sequencer.sv
`timescale 1ns / 1ps
// cpu_sequencer: control side of a small 16-bit CPU built around an external
// combinational ALU. Fetches instruction words from a synchronous program
// memory, decodes them, presents operands from a 4x16 register file plus a
// carry flag to the ALU, and writes results back. Handles immediate loads,
// absolute jumps, a carry-conditional jump and halt.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   imem_addr  program memory address (always the program counter)
//   imem_rdata program memory data, valid one cycle after imem_addr
//   instr      registered instruction word to the ALU
//   inreg1     R[instr[5:4]] to the ALU
//   inreg2     R[instr[3:2]] to the ALU
//   carryin    current carry flag to the ALU
//   aluout     ALU result
//   carryout   ALU carry/borrow out
//   halted     high once HALT has executed
//   dbg_sel    debug register read select
//   dbg_reg    R[dbg_sel], combinational
module cpu_sequencer #(
    parameter int unsigned     PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    output logic [15:0]     inreg1,
    output logic [15:0]     inreg2,
    output logic            carryin,
    input  logic [15:0]     aluout,
    input  logic            carryout,
    output logic            halted,
    input  logic [1:0]      dbg_sel,
    output logic [15:0]     dbg_reg
);

    localparam logic [7:0] OpAdd  = 8'hF8;
    localparam logic [7:0] OpSub  = 8'hF9;
    localparam logic [7:0] OpInc  = 8'hFA;
    localparam logic [7:0] OpDec  = 8'hFB;
    localparam logic [7:0] OpLdi  = 8'h10;
    localparam logic [7:0] OpJmp  = 8'h20;
    localparam logic [7:0] OpJc   = 8'h21;
    localparam logic [7:0] OpHalt = 8'hFF;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StImmF,
        StImmC,
        StExec,
        StHalted
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir_q;
    logic [15:0]     imm_q;
    logic [15:0]     rf_q [4];
    logic            carry_q;
    logic            halted_q;

    logic [7:0]  op;
    logic [1:0]  rd;
    logic        two_word;
    logic        ir_load, imm_load, pc_inc, pc_jump, rf_we, carry_we, halt_set;
    logic [15:0] rf_wdata;

    assign op = ir_q[15:8];
    assign rd = ir_q[7:6];

    // Two-word test looks at the word being latched into ir, not ir itself.
    assign two_word = (imem_rdata[15:8] == OpLdi) || (imem_rdata[15:8] == OpJmp) ||
                      (imem_rdata[15:8] == OpJc);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: state_d = two_word ? StImmF : StExec;
            StImmF:   state_d = StImmC;
            StImmC:   state_d = StExec;
            StExec:   state_d = (op == OpHalt) ? StHalted : StFetch;
            StHalted: state_d = StHalted;
            default:  state_d = StFetch;
        endcase
    end

    // Control outputs
    always_comb begin
        ir_load  = 1'b0;
        imm_load = 1'b0;
        pc_inc   = 1'b0;
        pc_jump  = 1'b0;
        rf_we    = 1'b0;
        rf_wdata = aluout;
        carry_we = 1'b0;
        halt_set = 1'b0;
        unique case (state_q)
            StDecode: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            StImmC: begin
                imm_load = 1'b1;
                pc_inc   = 1'b1;
            end
            StExec: begin
                case (op)
                    OpAdd, OpSub, OpInc, OpDec: begin
                        rf_we    = 1'b1;
                        carry_we = ir_q[1];
                    end
                    OpLdi: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm_q;
                    end
                    OpJmp:   pc_jump  = 1'b1;
                    OpJc:    pc_jump  = carry_q;
                    OpHalt:  halt_set = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Datapath state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RST_PC;
            ir_q     <= 16'h0000;
            imm_q    <= 16'h0000;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else begin
            if (ir_load) begin
                ir_q <= imem_rdata;
            end
            if (imm_load) begin
                imm_q <= imem_rdata;
            end
            if (pc_jump) begin
                pc_q <= imm_q[PC_W-1:0];
            end else if (pc_inc) begin
                pc_q <= pc_q + PC_W'(1);
            end
            if (rf_we) begin
                rf_q[rd] <= rf_wdata;
            end
            if (carry_we) begin
                carry_q <= carryout;
            end
            if (halt_set) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign imem_addr = pc_q;
    assign instr     = ir_q;
    assign inreg1    = rf_q[ir_q[5:4]];
    assign inreg2    = rf_q[ir_q[3:2]];
    assign carryin   = carry_q;
    assign halted    = halted_q;
    assign dbg_reg   = rf_q[dbg_sel];

endmodule

// File: tb/tb_cpu_sequencer.sv
`timescale 1ns / 1ps
// Directed bench for cpu_sequencer: a synchronous program memory and a small
// ALU model surround the DUT; register contents are observed via dbg_reg.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] inreg1;
    logic [15:0] inreg2;
    logic        carryin;
    logic [15:0] aluout;
    logic        carryout;
    logic        halted;
    logic [1:0]  dbg_sel;
    logic [15:0] dbg_reg;

    logic [15:0] mem [256];
    int          n_checks;
    int          n_errors;

    cpu_sequencer #(
        .PC_W   (8),
        .RST_PC (8'h00)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .inreg1     (inreg1),
        .inreg2     (inreg2),
        .carryin    (carryin),
        .aluout     (aluout),
        .carryout   (carryout),
        .halted     (halted),
        .dbg_sel    (dbg_sel),
        .dbg_reg    (dbg_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program memory
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    // ALU model: ir[0] gates carry-in; SUB reports borrow as carry
    logic cin;
    assign cin = instr[0] & carryin;
    always_comb begin
        {carryout, aluout} = 17'h0;
        case (instr[15:8])
            8'hF8: {carryout, aluout} = {1'b0, inreg1} + {1'b0, inreg2} + {16'h0, cin};
            8'hF9: {carryout, aluout} = {1'b0, inreg1} - {1'b0, inreg2} - {16'h0, cin};
            8'hFA: {carryout, aluout} = {1'b0, inreg1} + 17'h1;
            8'hFB: {carryout, aluout} = {1'b0, inreg1} - 17'h1;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [15:0] exp);
        dbg_sel = sel;
        #0.1;
        check(tag, {16'h0, dbg_reg}, {16'h0, exp});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Hold reset, check the reset state, release just after a falling edge
    // so the next rising edge is the first FETCH.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        step(2);
        check({tag, "_rst_pc"}, {24'h0, imem_addr}, 32'h0);
        check({tag, "_rst_halted"}, {31'h0, halted}, 32'h0);
        check({tag, "_rst_instr"}, {16'h0, instr}, 32'h0);
        check({tag, "_rst_carry"}, {31'h0, carryin}, 32'h0);
        for (int r = 0; r < 4; r++) chk_reg({tag, "_rst_reg"}, 2'(r), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        dbg_sel  = 2'd0;

        // Program A: ALU ops, carry handling, JC both ways, JMP, HALT
        clear_mem();
        mem[0]  = 16'h1040; mem[1]  = 16'hFFFF;   // LDI R1,FFFF
        mem[2]  = 16'h1080; mem[3]  = 16'h0001;   // LDI R2,0001
        mem[4]  = 16'hF8E6;                       // ADD R3=R2+R1, update carry
        mem[5]  = 16'h1040; mem[6]  = 16'h0003;   // LDI R1,3
        mem[7]  = 16'h1080; mem[8]  = 16'h0004;   // LDI R2,4
        mem[9]  = 16'hF8E5;                       // ADD+cin, carry kept
        mem[10] = 16'hF8E7;                       // ADD+cin, carry updated
        mem[11] = 16'hF8E5;                       // ADD, cin now 0
        mem[12] = 16'h2100; mem[13] = 16'h0040;   // JC 40 (not taken)
        mem[14] = 16'h1000; mem[15] = 16'h1111;   // LDI R0,1111
        mem[16] = 16'h1040; mem[17] = 16'hFFFF;   // LDI R1,FFFF
        mem[18] = 16'hF8E6;                       // ADD -> 0003, carry 1
        mem[19] = 16'h2100; mem[20] = 16'h0040;   // JC 40 (taken)
        mem[8'h40] = 16'h2000; mem[8'h41] = 16'hAB80; // JMP, target truncates to 80
        mem[8'h80] = 16'h10C0; mem[8'h81] = 16'h5555; // LDI R3,5555
        mem[8'h82] = 16'hFF00;                        // HALT
        do_reset("a");
        step(4);  chk_reg("ldi_r1_before_exec", 2'd1, 16'h0000);
        step(1);  chk_reg("ldi_r1_5cyc", 2'd1, 16'hFFFF);
        step(5);  chk_reg("ldi_r2", 2'd2, 16'h0001);
        step(2);
        check("add_instr", {16'h0, instr}, 32'h0000F8E6);
        check("add_inreg1", {16'h0, inreg1}, 32'h00000001);
        check("add_inreg2", {16'h0, inreg2}, 32'h0000FFFF);
        step(1);  chk_reg("add_wrap_r3", 2'd3, 16'h0000);
        check("add_wrap_carry", {31'h0, carryin}, 32'h1);
        step(13); chk_reg("adc_r3", 2'd3, 16'h0008);
        check("adc_nocarryupd", {31'h0, carryin}, 32'h1);
        step(3);  chk_reg("adc2_r3", 2'd3, 16'h0008);
        check("adc2_carry_cleared", {31'h0, carryin}, 32'h0);
        step(3);  chk_reg("add_cin0_r3", 2'd3, 16'h0007);
        step(5);  check("jc_not_taken_pc", {24'h0, imem_addr}, 32'h0E);
        step(5);  chk_reg("ldi_r0", 2'd0, 16'h1111);
        step(8);  chk_reg("add3_r3", 2'd3, 16'h0003);
        check("add3_carry", {31'h0, carryin}, 32'h1);
        step(5);  check("jc_taken_pc", {24'h0, imem_addr}, 32'h40);
        step(5);  check("jmp_pc", {24'h0, imem_addr}, 32'h80);
        step(5);  chk_reg("ldi_r3_after_jmp", 2'd3, 16'h5555);
        step(2);  check("halt_not_yet", {31'h0, halted}, 32'h0);
        step(1);  check("halt_set", {31'h0, halted}, 32'h1);
        check("halt_pc", {24'h0, imem_addr}, 32'h83);
        step(20);
        check("halt_pc_frozen", {24'h0, imem_addr}, 32'h83);
        check("halt_sticky", {31'h0, halted}, 32'h1);
        check("halt_carry_frozen", {31'h0, carryin}, 32'h1);
        chk_reg("final_r0", 2'd0, 16'h1111);
        chk_reg("final_r1", 2'd1, 16'hFFFF);
        chk_reg("final_r2", 2'd2, 16'h0004);
        chk_reg("final_r3", 2'd3, 16'h5555);

        // Program B: NOPs (incl. unknown opcode), INC, DEC, HALT at 5
        clear_mem();
        mem[1] = 16'h55C0;  // unknown opcode with rd=3: no write
        mem[2] = 16'hFAC0;  // INC R3=R0+1
        mem[3] = 16'hFB40;  // DEC R1=R0-1
        mem[5] = 16'hFF00;  // HALT
        do_reset("b");
        step(6);  chk_reg("nop_no_write", 2'd3, 16'h0000);
        step(3);  chk_reg("inc_r3", 2'd3, 16'h0001);
        step(3);  chk_reg("dec_r1", 2'd1, 16'hFFFF);
        step(5);  check("halt5_not_yet", {31'h0, halted}, 32'h0);
        step(1);  check("halt5_set", {31'h0, halted}, 32'h1);
        check("halt5_pc", {24'h0, imem_addr}, 32'h06);
        step(10);
        check("halt5_pc_frozen", {24'h0, imem_addr}, 32'h06);
        chk_reg("halt5_r3", 2'd3, 16'h0001);
        chk_reg("halt5_r1", 2'd1, 16'hFFFF);

        // Program C: LDI at FE with its immediate at FF, pc wraps to 00
        clear_mem();
        mem[0]     = 16'h2000; mem[1]     = 16'h00FE;
        mem[8'hFE] = 16'h1040; mem[8'hFF] = 16'hABCD;
        do_reset("c");
        step(5);  check("wrap_jmp_fe", {24'h0, imem_addr}, 32'hFE);
        step(3);  check("wrap_immf_ff", {24'h0, imem_addr}, 32'hFF);
        step(1);  check("wrap_pc_00", {24'h0, imem_addr}, 32'h00);
        step(1);  chk_reg("wrap_ldi_r1", 2'd1, 16'hABCD);

        // Program D: reset asserted during IMMC of an LDI
        clear_mem();
        mem[0] = 16'h1080; mem[1] = 16'h1234;
        do_reset("d");
        step(3);  check("d_immc_pc", {24'h0, imem_addr}, 32'h01);
        rst_n = 1'b0;
        #1;
        check("d_async_pc", {24'h0, imem_addr}, 32'h00);
        step(2);
        chk_reg("d_abort_r2", 2'd2, 16'h0000);
        check("d_abort_halted", {31'h0, halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4);  chk_reg("d_restart_r2_pre", 2'd2, 16'h0000);
        step(1);  chk_reg("d_restart_r2", 2'd2, 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
